// File: rtl/slow_memory_arb.sv
// Shared slow line memory: NUM_CH requesters, round-robin arbitration,
// one access in flight with independent read/write latencies.
module slow_memory_arb #(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = 128,
    parameter int DEPTH_LOG2 = 8,
    parameter int NUM_CH     = 2,
    parameter int RD_LAT     = 8,
    parameter int WR_LAT     = 8,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        mem_read,
    input  logic [NUM_CH-1:0]        mem_write,
    input  logic [NUM_CH*ADDR_W-1:0] mem_addr,
    input  logic [NUM_CH*DATA_W-1:0] mem_wdata,
    output logic [NUM_CH*DATA_W-1:0] mem_rdata,
    output logic [NUM_CH-1:0]        mem_ready,
    output logic                     busy,
    output logic [CH_W-1:0]          grant_ch
);

    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int LINES   = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [CH_W-1:0]         ptr_q;
    logic [CH_W-1:0]         lat_ch_q;
    logic                    lat_wr_q;
    logic [DEPTH_LOG2-1:0]   lat_idx_q;
    logic [DATA_W-1:0]       lat_wdata_q;
    logic [NUM_CH*DATA_W-1:0] rdata_q;
    logic [NUM_CH-1:0]       ready_q;

    logic [DATA_W-1:0]       mem [LINES];

    logic [NUM_CH-1:0]       req;
    logic                    win_found;
    logic [CH_W-1:0]         win_ch;
    int                      scan_idx;
    logic                    do_grant, do_done;
    logic [CH_W-1:0]         ptr_next;

    // Only the low DEPTH_LOG2 address bits select a line; the rest alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr;

    // Round-robin search starting at the pointer, wrapping at NUM_CH.
    always_comb begin
        req       = mem_read | mem_write;
        win_found = 1'b0;
        win_ch    = '0;
        scan_idx  = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            scan_idx = int'(ptr_q) + i;
            if (scan_idx >= NUM_CH) scan_idx = scan_idx - NUM_CH;
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_ch    = CH_W'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        do_grant = 1'b0;
        do_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    do_grant = 1'b1;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    do_done = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign ptr_next = (lat_ch_q == CH_W'(NUM_CH - 1)) ? '0 : lat_ch_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            ptr_q       <= '0;
            lat_ch_q    <= '0;
            lat_wr_q    <= 1'b0;
            lat_idx_q   <= '0;
            lat_wdata_q <= '0;
            rdata_q     <= '0;
            ready_q     <= '0;
            grant_ch    <= '0;
        end else begin
            if (do_grant) begin
                lat_ch_q    <= win_ch;
                lat_wr_q    <= mem_write[win_ch];
                lat_idx_q   <= mem_addr[int'(win_ch)*ADDR_W +: DEPTH_LOG2];
                lat_wdata_q <= mem_wdata[int'(win_ch)*DATA_W +: DATA_W];
                grant_ch    <= win_ch;
                cnt_q       <= mem_write[win_ch] ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);
            end else if (state_q == ACCESS && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (do_done) begin
                ready_q[lat_ch_q] <= 1'b1;
                if (!lat_wr_q) rdata_q[int'(lat_ch_q)*DATA_W +: DATA_W] <= mem[lat_idx_q];
            end
            if (state_q == RESP) begin
                ready_q <= '0;
                ptr_q   <= ptr_next;
            end
        end
    end

    // Storage is never reset; a reset edge suppresses a pending write.
    always_ff @(posedge clk) begin
        if (!rst && do_done && lat_wr_q) mem[lat_idx_q] <= lat_wdata_q;
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/slow_memory_arb.md
Name: slow_memory_arb

Overview:
- Parametrised successor of the bench's single-channel slow line memory.
- One storage array is shared by NUM_CH requester channels (e.g. I-cache and D-cache) through round-robin arbitration.
- Read and write latencies are set independently; line width and depth are configurable.
- Sits between CHIP cache ports and the bench as a shared backing store, so cross-channel contention and self-modifying-code cases can be tested.

Parameters:
- ADDR_W, 28, line-address width per channel (byte address bits [31:4])
- DATA_W, 128, line width in bits
- DEPTH_LOG2, 8, log2 of line count; array index = addr[DEPTH_LOG2-1:0]
- NUM_CH, 2, number of requester channels (1..8); channel 0 has highest index priority after reset
- RD_LAT, 8, cycles from grant edge to read ready (>=1)
- WR_LAT, 8, cycles from grant edge to write ready (>=1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- mem_read  in  NUM_CH  per-channel read request (level, held until ready)
- mem_write  in  NUM_CH  per-channel write request (level, held until ready)
- mem_addr  in  NUM_CH*ADDR_W  packed line addresses, channel c at [c*ADDR_W +: ADDR_W]
- mem_wdata  in  NUM_CH*DATA_W  packed write lines
- mem_rdata  out  NUM_CH*DATA_W  packed read lines, valid while the channel's ready is high
- mem_ready  out  NUM_CH  one-cycle completion pulse per channel
- busy  out  1  high in ACCESS or RESP
- grant_ch  out  $clog2(NUM_CH) (min 1)  channel currently or last served

Behaviour:
- Reset values: state IDLE; mem_ready all 0; mem_rdata all 0; busy 0; grant_ch 0; round-robin pointer 0.
- Array contents are not reset. The bench preloads them with $readmemh/$readmemb.
- The FSM has three states: IDLE, ACCESS, RESP.
- IDLE: a channel requests if mem_read or mem_write is high. The winner is the first requesting channel searching from the pointer upward, wrapping at NUM_CH.
- On the grant edge the block latches:
  - channel
  - op: write if mem_write is high, including when read and write are asserted together
  - array index
  - wdata
- On the grant edge it also loads the counter with RD_LAT-1 or WR_LAT-1, sets grant_ch and goes to ACCESS.
- With no requests in IDLE the block does nothing.
- ACCESS: the counter decrements every cycle. Inputs are ignored, since the latched values are used.
- When the counter is 0, on that edge:
  - a read loads the latched channel's mem_rdata slice from the array;
  - a write updates the array line;
  - mem_ready for that channel is set to 1 and the FSM goes to RESP.
- Latency: if grant is sampled at edge E0, mem_ready is high in the cycle after edge E0+LAT (LAT = RD_LAT or WR_LAT).
- RESP: lasts exactly one cycle with mem_ready high. On exit, mem_ready clears, the pointer moves to granted+1 (mod NUM_CH) and the FSM goes to IDLE.
- Requesters must drop their request at the edge closing RESP. Because IDLE samples on the following edge, the same request is never serviced twice.
- mem_rdata holds its last value after ready drops. Other channels' rdata slices are unchanged.
- A request dropped mid-ACCESS has no effect: the access completes and ready still pulses.
- A request changed mid-ACCESS (address, data or op) is not seen until the next grant.
- Address bits above DEPTH_LOG2 are ignored, so addresses alias and wrap modulo 2^DEPTH_LOG2.
- A read after a write to the same line, from any channel, returns the written data. No write buffering.
- rst asserted in any state takes effect at the next edge:
  - the access in flight is abandoned;
  - no array write occurs for a write not yet at counter 0;
  - ready is cleared.
- busy = (state != IDLE). Throughput is at most one access per LAT+2 cycles.

Test Plan:
- Single read, NUM_CH=2, RD_LAT=8: preload line 5 = 128'hA5..A5; ch0 read addr 5 at grant edge E0 -> mem_ready[0] high exactly in the cycle after E0+8, rdata slice0 = A5..A5, ready[1] stays 0.
- Write then read: ch1 writes line 3 = 128'h1234 (WR_LAT=4), then ch0 reads line 3 -> ready[1] in the cycle after grant+4; the ch0 read returns 128'h1234.
- Contention/fairness: ch0 and ch1 both request continuously from reset -> grants alternate 0,1,0,1; each pulse of ready is one cycle; no channel is served twice in a row.
- Simultaneous read+write on ch0 to line 7 with wdata 128'hFF -> treated as write; a subsequent read of line 7 returns 128'hFF.
- Address wrap, DEPTH_LOG2=8: write to addr 28'h105, read addr 28'h005 -> same data returned.
- Reset mid-ACCESS: assert rst 3 cycles into a write to line 9 (old 128'h0) -> ready never pulses, busy=0 after next edge, line 9 reads back 128'h0.
